issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_issue_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// Dual-issue controller: decodes the two buffer head entries, checks them against a
// load scoreboard and each other, and decides how many launch into ID this cycle.
module issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid1,
  input  logic        valid2,
  input  logic [31:0] inst1,
  input  logic [31:0] inst2,
  input  logic        branch_flag,
  input  logic        id_stall,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  output logic        launch_flag1,
  output logic        launch_flag2,
  output logic [1:0]  issue_cnt,
  output logic [15:0] stall_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  function automatic logic [6:0] f_op(input logic [31:0] w);
    return w[6:0];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] w);
    return w[11:7];
  endfunction

  function automatic logic [4:0] f_rs1(input logic [31:0] w);
    return w[19:15];
  endfunction

  function automatic logic [4:0] f_rs2(input logic [31:0] w);
    return w[24:20];
  endfunction

  function automatic logic f_uses_rs1(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  function automatic logic f_uses_rs2(input logic [6:0] op);
    return (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic f_writes_rd(input logic [6:0] op, input logic [4:0] rd);
    return !((op == OP_STORE) || (op == OP_BRANCH)) && (rd != 5'd0);
  endfunction

  function automatic logic f_is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic f_is_ctrl(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_busy;
  logic [31:0] w_busy_nxt;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;
  logic [15:0] r_stall_cnt;

  logic [6:0]  w_op1;
  logic [6:0]  w_op2;
  logic [4:0]  w_rd1;
  logic [4:0]  w_rd2;
  logic [4:0]  w_rs1_1;
  logic [4:0]  w_rs2_1;
  logic [4:0]  w_rs1_2;
  logic [4:0]  w_rs2_2;
  logic        w_wr1;
  logic        w_wr2;
  logic        w_busy_hit1;
  logic        w_busy_hit2;
  logic        w_raw12;
  logic        w_pair_ok;
  logic        w_launch1;
  logic        w_launch2;

  assign w_op1   = f_op(inst1);
  assign w_op2   = f_op(inst2);
  assign w_rd1   = f_rd(inst1);
  assign w_rd2   = f_rd(inst2);
  assign w_rs1_1 = f_rs1(inst1);
  assign w_rs2_1 = f_rs2(inst1);
  assign w_rs1_2 = f_rs1(inst2);
  assign w_rs2_2 = f_rs2(inst2);
  assign w_wr1   = f_writes_rd(w_op1, w_rd1);
  assign w_wr2   = f_writes_rd(w_op2, w_rd2);

  // Hazard checks use only the registered scoreboard, so a writeback helps next cycle.
  assign w_busy_hit1 = (f_uses_rs1(w_op1) && r_busy[w_rs1_1]) ||
                       (f_uses_rs2(w_op1) && r_busy[w_rs2_1]);
  assign w_busy_hit2 = (f_uses_rs1(w_op2) && r_busy[w_rs1_2]) ||
                       (f_uses_rs2(w_op2) && r_busy[w_rs2_2]);
  assign w_raw12     = w_wr1 && ((f_uses_rs1(w_op2) && (w_rs1_2 == w_rd1)) ||
                                 (f_uses_rs2(w_op2) && (w_rs2_2 == w_rd1)));
  assign w_pair_ok   = !w_raw12 && !f_is_ctrl(w_op1) &&
                       !(f_is_mem(w_op1) && f_is_mem(w_op2));

  assign w_launch1 = rst && (r_state == S_RUN) && !branch_flag && !id_stall &&
                     valid1 && !w_busy_hit1;
  assign w_launch2 = w_launch1 && valid2 && !w_busy_hit2 && w_pair_ok;

  assign launch_flag1 = w_launch1;
  assign launch_flag2 = w_launch2;
  assign issue_cnt    = {1'b0, w_launch1} + {1'b0, w_launch2};
  assign stall_cnt    = r_stall_cnt;

  // Flush lasts one cycle beyond the last cycle branch_flag is seen.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (branch_flag) begin
          w_state_nxt = S_FLUSH;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_FLUSH: begin
        if (branch_flag) begin
          w_state_nxt = S_FLUSH;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Scoreboard next value: set is applied after clear so a new producer wins.
  always_comb begin
    w_set_mask = 32'd0;
    w_clr_mask = 32'd0;
    if (wb_en && (wb_rd != 5'd0)) begin
      w_clr_mask[wb_rd] = 1'b1;
    end else begin
      w_clr_mask = 32'd0;
    end
    if (w_launch1 && (w_op1 == OP_LOAD) && w_wr1) begin
      w_set_mask[w_rd1] = 1'b1;
    end else begin
      w_set_mask[0] = 1'b0;
    end
    if (w_launch2 && (w_op2 == OP_LOAD) && w_wr2) begin
      w_set_mask[w_rd2] = 1'b1;
    end else begin
      w_set_mask[0] = 1'b0;
    end
    w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
  end

  // State, scoreboard and saturating stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_busy      <= 32'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      if ((r_state == S_RUN) && valid1 && !w_launch1 && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: each step drives one cycle of inputs at the falling
// edge and checks the combinational launch outputs and the registered stall counter.
module tb_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        valid1;
  logic        valid2;
  logic [31:0] inst1;
  logic [31:0] inst2;
  logic        branch_flag;
  logic        id_stall;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic        launch_flag1;
  logic        launch_flag2;
  logic [1:0]  issue_cnt;
  logic [15:0] stall_cnt;

  int n_chk;
  int n_fail;

  issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .valid1       (valid1),
    .valid2       (valid2),
    .inst1        (inst1),
    .inst2        (inst2),
    .branch_flag  (branch_flag),
    .id_stall     (id_stall),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .launch_flag1 (launch_flag1),
    .launch_flag2 (launch_flag2),
    .issue_cnt    (issue_cnt),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] e_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] e_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] e_sw(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  function automatic logic [31:0] e_beq(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, 5'd0, 7'b1100011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e1, input logic e2,
                         input logic [1:0] ecnt, input logic [15:0] estall);
    chk({tag, ".l1"}, {31'd0, launch_flag1}, {31'd0, e1});
    chk({tag, ".l2"}, {31'd0, launch_flag2}, {31'd0, e2});
    chk({tag, ".cnt"}, {30'd0, issue_cnt}, {30'd0, ecnt});
    chk({tag, ".stall"}, {16'd0, stall_cnt}, {16'd0, estall});
  endtask

  task automatic drive(input logic v1, input logic [31:0] i1, input logic v2, input logic [31:0] i2,
                       input logic br, input logic st, input logic we, input logic [4:0] wr);
    @(negedge clk);
    valid1      = v1;
    inst1       = i1;
    valid2      = v2;
    inst2       = i2;
    branch_flag = br;
    id_stall    = st;
    wb_en       = we;
    wb_rd       = wr;
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst         = 1'b0;
    valid1      = 1'b1;
    valid2      = 1'b1;
    inst1       = e_add(5'd1, 5'd2, 5'd3);
    inst2       = e_add(5'd4, 5'd5, 5'd6);
    branch_flag = 1'b0;
    id_stall    = 1'b0;
    wb_en       = 1'b0;
    wb_rd       = 5'd0;
    #1;
    chk_all("reset", 1'b0, 1'b0, 2'd0, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_held", 1'b0, 1'b0, 2'd0, 16'd0);
    @(negedge clk);
    valid1 = 1'b0;
    valid2 = 1'b0;
    rst    = 1'b1;

    // Two independent ADDs dual-issue
    drive(1'b1, e_add(5'd1, 5'd2, 5'd3), 1'b1, e_add(5'd4, 5'd5, 5'd6), 1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("dual_add", 1'b1, 1'b1, 2'd2, 16'd0);
    // RAW between slots
    drive(1'b1, e_add(5'd1, 5'd2, 5'd3), 1'b1, e_add(5'd7, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("raw_pair", 1'b1, 1'b0, 2'd1, 16'd0);
    // LW x5 sets busy[5]
    drive(1'b1, e_lw(5'd5, 5'd2), 1'b0, e_add(5'd5, 5'd5, 5'd5), 1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("lw_x5", 1'b1, 1'b0, 2'd1, 16'd0);
    drive(1'b1, e_add(5'd6, 5'd5, 5'd0), 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("use_x5_a", 1'b0, 1'b0, 2'd0, 16'd0);
    drive(1'b1, e_add(5'd6, 5'd5, 5'd0), 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5);
    chk_all("use_x5_wb", 1'b0, 1'b0, 2'd0, 16'd1);
    drive(1'b1, e_add(5'd6, 5'd5, 5'd0), 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("use_x5_go", 1'b1, 1'b0, 2'd1, 16'd2);

    // Branch flush: blocked on the flag cycle and the FLUSH cycle
    drive(1'b1, e_add(5'd1, 5'd2, 5'd3), 1'b1, e_add(5'd4, 5'd5, 5'd6), 1'b1, 1'b0, 1'b0, 5'd0);
    chk_all("br_cyc", 1'b0, 1'b0, 2'd0, 16'd2);
    drive(1'b1, e_add(5'd1, 5'd2, 5'd3), 1'b1, e_add(5'd4, 5'd5, 5'd6), 1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("flush_cyc", 1'b0, 1'b0, 2'd0, 16'd3);
    drive(1'b1, e_add(5'd1, 5'd2, 5'd3), 1'b1, e_add(5'd4, 5'd5, 5'd6), 1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("resume", 1'b1, 1'b1, 2'd2, 16'd3);

    // Two memory ops, then control op in slot 1 (also retire x8)
    drive(1'b1, e_lw(5'd8, 5'd2), 1'b1, e_sw(5'd9, 5'd10), 1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("lw_sw", 1'b1, 1'b0, 2'd1, 16'd3);
    drive(1'b1, e_beq(5'd1, 5'd2), 1'b1, e_add(5'd12, 5'd2, 5'd3), 1'b0, 1'b0, 1'b1, 5'd8);
    chk_all("beq_slot1", 1'b1, 1'b0, 2'd1, 16'd3);
    // LW x9 while x9 writes back: set wins; slot 2 reads freed x8
    drive(1'b1, e_lw(5'd9, 5'd2), 1'b1, e_add(5'd13, 5'd8, 5'd0), 1'b0, 1'b0, 1'b1, 5'd9);
    chk_all("set_clr", 1'b1, 1'b1, 2'd2, 16'd3);
    drive(1'b1, e_add(5'd10, 5'd9, 5'd0), 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("x9_busy", 1'b0, 1'b0, 2'd0, 16'd3);
    // ADDI imm field = 9 and LUI rs1 field = 9 are not register reads
    drive(1'b1, {12'd9, 5'd2, 3'd0, 5'd1, 7'b0010011}, 1'b1, {12'd0, 5'd9, 3'd0, 5'd14, 7'b0110111},
          1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("unused_src", 1'b1, 1'b1, 2'd2, 16'd4);
    drive(1'b0, e_add(5'd1, 5'd2, 5'd3), 1'b1, e_add(5'd4, 5'd5, 5'd6), 1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("no_valid1", 1'b0, 1'b0, 2'd0, 16'd4);
    drive(1'b1, e_add(5'd1, 5'd2, 5'd3), 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    chk_all("id_stall", 1'b0, 1'b0, 2'd0, 16'd4);
    drive(1'b1, e_lw(5'd3, 5'd2), 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("lw_x3", 1'b1, 1'b0, 2'd1, 16'd5);

    // Reset mid-cycle discards busy[3] and busy[9]
    drive(1'b1, e_add(5'd4, 5'd3, 5'd0), 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("x3_busy", 1'b0, 1'b0, 2'd0, 16'd5);
    drive(1'b1, e_add(5'd4, 5'd3, 5'd0), 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("x3_busy2", 1'b0, 1'b0, 2'd0, 16'd6);
    #2;
    rst = 1'b0;
    #1;
    chk_all("mid_rst", 1'b0, 1'b0, 2'd0, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all("post_rst", 1'b1, 1'b0, 2'd1, 16'd0);
    drive(1'b1, e_add(5'd10, 5'd9, 5'd0), 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("x9_freed", 1'b1, 1'b0, 2'd1, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
